mem_io_bridge: RTL and testbench

//  Memory-mapped data-side bridge directly downstream of the single-cycle CPU core.
//  - Consumes the core's data-memory request: address = ALU.C, write data = RF.rd2, write enable = dram_we.
//  - Returns the read data that the core writes back as DRAM.rd.
//  - Routes each access to the data DRAM or to on-board peripherals: LEDs, switches,

---
 rtl/mem_io_bridge.sv | 137 +++++++++++++
 tb/tb_mem_io_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_io_bridge: data-side bridge routing core loads/stores to DRAM or to     |
// | LED/switch/button/7-segment/timer peripherals.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
module mem_io_bridge #(
    parameter int SCAN_DIV = 50000,
    parameter int DRAM_AW  = 14
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_wdata_i,
    output logic [31:0]        cpu_rdata_o,
    output logic [DRAM_AW-1:0] dram_addr_o,
    output logic               dram_we_o,
    output logic [31:0]        dram_wdata_o,
    input  logic [31:0]        dram_rdata_i,
    input  logic [23:0]        sw_i,
    input  logic [4:0]         btn_i,
    output logic [23:0]        led_o,
    output logic [7:0]         dig_en_o,
    output logic [7:0]         dig_seg_o
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Word offsets within the IO page (cpu_addr[11:2])
    localparam logic [9:0] OFS_SEG   = 10'h000;
    localparam logic [9:0] OFS_TIMER = 10'h008;
    localparam logic [9:0] OFS_LED   = 10'h018;
    localparam logic [9:0] OFS_SW    = 10'h01C;
    localparam logic [9:0] OFS_BTN   = 10'h01E;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [31:0]       seg_q,   seg_d;
    logic [31:0]       timer_q, timer_d;
    logic [23:0]       led_q,   led_d;
    logic [23:0]       sw_s1_q, sw_s2_q;
    logic [4:0]        btn_s1_q, btn_s2_q;
    logic [SCAN_W-1:0] scan_q,  scan_d;
    logic [2:0]        idx_q,   idx_d;
    logic [7:0]        dig_en_q, dig_seg_q;

    logic       w_is_io;
    logic [9:0] w_ofs;
    logic       w_io_we;
    logic       w_unused_addr;

    assign w_is_io       = (cpu_addr_i[31:12] == 20'hFFFFF);
    assign w_ofs         = cpu_addr_i[11:2];
    assign w_io_we       = cpu_we_i & w_is_io;
    assign w_unused_addr = ^cpu_addr_i[1:0];

    assign dram_addr_o  = cpu_addr_i[DRAM_AW+1:2];
    assign dram_we_o    = cpu_we_i & ~w_is_io;
    assign dram_wdata_o = cpu_wdata_i;

    always_comb begin
        cpu_rdata_o = 32'h0;
        if (!w_is_io) begin
            cpu_rdata_o = dram_rdata_i;
        end else begin
            case (w_ofs)
                OFS_SEG:   cpu_rdata_o = seg_q;
                OFS_TIMER: cpu_rdata_o = timer_q;
                OFS_LED:   cpu_rdata_o = {8'h0, led_q};
                OFS_SW:    cpu_rdata_o = {8'h0, sw_s2_q};
                OFS_BTN:   cpu_rdata_o = {27'h0, btn_s2_q};
                default:   cpu_rdata_o = 32'h0;
            endcase
        end
    end

    always_comb begin
        seg_d   = seg_q;
        led_d   = led_q;
        // A store to the timer takes priority over the free-running increment
        timer_d = timer_q + 32'd1;
        if (w_io_we && (w_ofs == OFS_SEG))   seg_d   = cpu_wdata_i;
        if (w_io_we && (w_ofs == OFS_LED))   led_d   = cpu_wdata_i[23:0];
        if (w_io_we && (w_ofs == OFS_TIMER)) timer_d = cpu_wdata_i;

        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seg_q     <= 32'h0;
            timer_q   <= 32'h0;
            led_q     <= 24'h0;
            sw_s1_q   <= 24'h0;
            sw_s2_q   <= 24'h0;
            btn_s1_q  <= 5'h0;
            btn_s2_q  <= 5'h0;
            scan_q    <= '0;
            idx_q     <= 3'd0;
            dig_en_q  <= 8'hFF;
            dig_seg_q <= 8'hFF;
        end else begin
            seg_q     <= seg_d;
            timer_q   <= timer_d;
            led_q     <= led_d;
            sw_s1_q   <= sw_i;
            sw_s2_q   <= sw_s1_q;
            btn_s1_q  <= btn_i;
            btn_s2_q  <= btn_s1_q;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            dig_en_q  <= ~(8'd1 << idx_q);
            dig_seg_q <= hex7(seg_q[{idx_q, 2'b00} +: 4]);
        end
    end

    assign led_o     = led_q;
    assign dig_en_o  = dig_en_q;
    assign dig_seg_o = dig_seg_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_io_bridge: directed self-checking bench for mem_io_bridge.  Rev 1.0  |
// +----------------------------------------------------------------------------+
module tb_mem_io_bridge;

    localparam int DRAM_AW = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        cpu_addr;
    logic               cpu_we;
    logic [31:0]        cpu_wdata;
    logic [31:0]        cpu_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_we;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic [23:0]        sw;
    logic [4:0]         btn;
    logic [23:0]        led;
    logic [7:0]         dig_en;
    logic [7:0]         dig_seg;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:15];
    logic [7:0]  exp_en  [0:7];
    logic [7:0]  exp_seg [0:7];

    always #5 clk = ~clk;

    mem_io_bridge #(.SCAN_DIV(4), .DRAM_AW(DRAM_AW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cpu_addr_i   (cpu_addr),
        .cpu_we_i     (cpu_we),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .dram_addr_o  (dram_addr),
        .dram_we_o    (dram_we),
        .dram_wdata_o (dram_wdata),
        .dram_rdata_i (dram_rdata),
        .sw_i         (sw),
        .btn_i        (btn),
        .led_o        (led),
        .dig_en_o     (dig_en),
        .dig_seg_o    (dig_seg)
    );

    // Small DRAM model: combinational read, write on posedge
    assign dram_rdata = mem[dram_addr[3:0]];
    always @(posedge clk) begin
        if (dram_we) mem[dram_addr[3:0]] <= dram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        exp_en[0] = 8'hFE; exp_en[1] = 8'hFD; exp_en[2] = 8'hFB; exp_en[3] = 8'hF7;
        exp_en[4] = 8'hEF; exp_en[5] = 8'hDF; exp_en[6] = 8'hBF; exp_en[7] = 8'h7F;
        // SEG = 0x89ABCDEF: digit k shows nibble k (F,E,D,C,B,A,9,8)
        exp_seg[0] = 8'h8E; exp_seg[1] = 8'h86; exp_seg[2] = 8'hA1; exp_seg[3] = 8'hC6;
        exp_seg[4] = 8'h83; exp_seg[5] = 8'h88; exp_seg[6] = 8'h90; exp_seg[7] = 8'h80;

        rst_n = 1'b0; cpu_addr = 32'h0; cpu_we = 1'b0; cpu_wdata = 32'h0;
        sw = 24'h0; btn = 5'h0;
        tick(); tick();
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("rst_dig_seg", {24'h0, dig_seg}, 32'hFF);
        cpu_addr = 32'hFFFF_F020; #1;
        check("rst_timer", cpu_rdata, 32'h0);
        rst_n = 1'b1;

        // DRAM store then load
        cpu_addr = 32'h0000_0010; cpu_we = 1'b1; cpu_wdata = 32'h1234_5678; #1;
        check("dram_we_store", {31'h0, dram_we}, 32'h1);
        check("dram_addr", {18'h0, dram_addr}, 32'h4);
        check("dram_wdata", dram_wdata, 32'h1234_5678);
        tick();
        cpu_we = 1'b0; #1;
        check("dram_load", cpu_rdata, 32'h1234_5678);
        check("led_after_dram", {8'h0, led}, 32'h0);

        // LED store
        cpu_addr = 32'hFFFF_F060; cpu_we = 1'b1; cpu_wdata = 32'h00A5_A5A5; #1;
        check("led_dram_we", {31'h0, dram_we}, 32'h0);
        tick();
        cpu_we = 1'b0; #1;
        check("led_out", {8'h0, led}, 32'h00A5_A5A5);
        check("led_read", cpu_rdata, 32'h00A5_A5A5);

        // SEG store (nonzero for the later reset test)
        cpu_addr = 32'hFFFF_F000; cpu_we = 1'b1; cpu_wdata = 32'h0000_0011;
        tick();
        cpu_we = 1'b0; #1;
        check("seg_read", cpu_rdata, 32'h0000_0011);

        // Switch/button synchronisers
        sw = 24'h00FF00; btn = 5'b10001;
        cpu_addr = 32'hFFFF_F070; #1;
        check("sw_sync0", cpu_rdata, 32'h0);
        tick();
        check("sw_sync1", cpu_rdata, 32'h0);
        tick();
        check("sw_sync2", cpu_rdata, 32'h0000_FF00);
        cpu_addr = 32'hFFFF_F078; #1;
        check("btn_read", cpu_rdata, 32'h0000_0011);
        cpu_addr = 32'hFFFF_F070; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFF; #1;
        check("sw_store_dram_we", {31'h0, dram_we}, 32'h0);
        tick();
        cpu_we = 1'b0; #1;
        check("sw_store_ignored", cpu_rdata, 32'h0000_FF00);

        // Unmapped IO address
        cpu_addr = 32'hFFFF_F004; cpu_we = 1'b1; cpu_wdata = 32'hDEAD_BEEF; #1;
        check("unmapped_dram_we", {31'h0, dram_we}, 32'h0);
        check("unmapped_read", cpu_rdata, 32'h0);
        tick();
        cpu_we = 1'b0; #1;
        check("unmapped_after", cpu_rdata, 32'h0);

        // Timer load and wrap
        cpu_addr = 32'hFFFF_F020; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFE;
        tick();
        cpu_we = 1'b0; #1;
        check("timer_load", cpu_rdata, 32'hFFFF_FFFE);
        tick();
        check("timer_max", cpu_rdata, 32'hFFFF_FFFF);
        tick();
        check("timer_wrap", cpu_rdata, 32'h0);
        tick();
        check("timer_inc", cpu_rdata, 32'h1);
        cpu_we = 1'b1; cpu_wdata = 32'h0000_0100;
        tick();
        cpu_we = 1'b0; #1;
        check("timer_store_wins", cpu_rdata, 32'h0000_0100);
        tick();
        check("timer_after_store", cpu_rdata, 32'h0000_0101);

        // Mid-operation reset with a concurrent LED store
        rst_n = 1'b0;
        cpu_addr = 32'hFFFF_F060; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFF;
        tick();
        cpu_we = 1'b0; #1;
        check("mid_rst_led", {8'h0, led}, 32'h0);
        check("mid_rst_led_read", cpu_rdata, 32'h0);
        check("mid_rst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("mid_rst_dig_seg", {24'h0, dig_seg}, 32'hFF);
        cpu_addr = 32'hFFFF_F020; #1;
        check("mid_rst_timer", cpu_rdata, 32'h0);
        cpu_addr = 32'hFFFF_F000; #1;
        check("mid_rst_seg", cpu_rdata, 32'h0);

        // Display scan with SCAN_DIV=4, SEG stored on first edge after release
        rst_n = 1'b1;
        cpu_addr = 32'hFFFF_F000; cpu_we = 1'b1; cpu_wdata = 32'h89AB_CDEF;
        tick();
        cpu_we = 1'b0; #1;
        check("scan_first_en", {24'h0, dig_en}, 32'hFE);
        check("scan_first_seg", {24'h0, dig_seg}, 32'hC0);
        tick();
        check("scan_seg_next", {24'h0, dig_seg}, 32'h8E);
        tick(); tick();
        check("scan_en_d0", {24'h0, dig_en}, {24'h0, exp_en[0]});
        check("scan_seg_d0", {24'h0, dig_seg}, {24'h0, exp_seg[0]});
        for (int k = 1; k < 8; k++) begin
            tick(); tick(); tick(); tick();
            check("scan_en", {24'h0, dig_en}, {24'h0, exp_en[k]});
            check("scan_seg", {24'h0, dig_seg}, {24'h0, exp_seg[k]});
        end
        tick(); tick(); tick(); tick();
        check("scan_wrap_en", {24'h0, dig_en}, 32'hFE);
        check("scan_wrap_seg", {24'h0, dig_seg}, 32'h8E);

        cpu_addr = 32'h0000_0010; #1;
        check("dram_kept", cpu_rdata, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
